// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake bundle between the UART receiver and its register/FIFO wrapper.
// master = receiver (produces words), slave = consumer (returns rx_ready).
interface uart_rx_cfg_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_parity_err;
    logic              rx_frame_err;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_overrun;

    modport master (
        output rx_data,
        output rx_parity_err,
        output rx_frame_err,
        output rx_valid,
        output rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_valid,
        input  rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: programmable divisor, 5..DATA_W data bits,
// optional parity, 1/2 stop bits, 3-sample majority voting and a valid/ready output.
module uart_rx_cfg #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             rx,
    input  logic             cfg_en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [3:0]       cfg_data_bits,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_odd,
    input  logic             cfg_stop2,
    output logic             busy,
    uart_rx_cfg_if.master    rx_if
);

    localparam int TW = $clog2(OVS);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] T_LO   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVS / 2);
    localparam logic [TW-1:0] T_HI   = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [3:0]    MAX_BITS = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              rx_s_q, rx_s_d;
    logic              rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [1:0]        samp_q, samp_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_acc_q, par_acc_d;
    logic              par_err_q, par_err_d;
    logic              frame_err_q, frame_err_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        nbits_q, nbits_d;
    logic              par_en_q, par_en_d;
    logic              par_odd_q, par_odd_d;
    logic              stop2_q, stop2_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_perr_q, out_perr_d;
    logic              out_ferr_q, out_ferr_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic              tick, mid, bit_end, maj, deliver, start_det;
    logic [3:0]        nbits_cfg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            samp_q      <= '0;
            data_q      <= '0;
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            div_q       <= '0;
            nbits_q     <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            out_data_q  <= '0;
            out_perr_q  <= 1'b0;
            out_ferr_q  <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            samp_q      <= samp_d;
            data_q      <= data_d;
            par_acc_q   <= par_acc_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            div_q       <= div_d;
            nbits_q     <= nbits_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            stop2_q     <= stop2_d;
            out_data_q  <= out_data_d;
            out_perr_q  <= out_perr_d;
            out_ferr_q  <= out_ferr_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        sync1_d     = rx;
        rx_s_d      = sync1_q;
        rx_prev_d   = rx_s_q;
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        samp_d      = samp_q;
        data_d      = data_q;
        par_acc_d   = par_acc_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        div_d       = div_q;
        nbits_d     = nbits_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        stop2_d     = stop2_q;
        out_data_d  = out_data_q;
        out_perr_d  = out_perr_q;
        out_ferr_d  = out_ferr_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        nbits_cfg = (cfg_data_bits < 4'd5) ? 4'd5 :
                    ((cfg_data_bits > MAX_BITS) ? MAX_BITS : cfg_data_bits);
        start_det = cfg_en && rx_prev_q && !rx_s_q;
        tick      = (div_cnt_q == div_q);
        mid       = tick && (tick_cnt_q == T_HI);
        bit_end   = tick && (tick_cnt_q == T_LAST);
        maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

        if (state_q != S_IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + TW'(1);
                if (tick_cnt_q == T_LO)  samp_d[0] = rx_s_q;
                if (tick_cnt_q == T_MID) samp_d[1] = rx_s_q;
            end
        end

        // Frame config is latched at the start edge so mid-frame cfg writes are harmless.
        case (state_q)
            S_IDLE: begin
                div_cnt_d  = '0;
                tick_cnt_d = '0;
                if (start_det) begin
                    state_d     = S_START;
                    bit_cnt_d   = '0;
                    stop_cnt_d  = 1'b0;
                    data_d      = '0;
                    par_acc_d   = 1'b0;
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    div_d       = cfg_div;
                    nbits_d     = nbits_cfg;
                    par_en_d    = cfg_parity_en;
                    par_odd_d   = cfg_parity_odd;
                    stop2_d     = cfg_stop2;
                end
            end
            S_START: begin
                if (mid && maj) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (mid) begin
                    data_d[bit_cnt_q[BW-1:0]] = maj;
                    par_acc_d = par_acc_q ^ maj;
                end
                if (bit_end) begin
                    if (bit_cnt_q == nbits_q - 4'd1) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (mid) par_err_d = par_acc_q ^ maj ^ par_odd_q;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // The final stop bit ends at its mid-point so a back-to-back start edge is caught.
                if (mid) begin
                    if (!maj) frame_err_d = 1'b1;
                    if (!stop2_q || stop_cnt_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                if (bit_end) stop_cnt_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q != S_IDLE) && !cfg_en) begin
            state_d = S_IDLE;
            deliver = 1'b0;
        end

        if (valid_q && rx_if.rx_ready) valid_d = 1'b0;
        if (deliver) begin
            if (!valid_q || rx_if.rx_ready) begin
                out_data_d = data_q;
                out_perr_d = par_err_q;
                out_ferr_d = frame_err_d;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_if.rx_data       = out_data_q;
    assign rx_if.rx_parity_err = out_perr_q;
    assign rx_if.rx_frame_err  = out_ferr_q;
    assign rx_if.rx_valid      = valid_q;
    assign rx_if.rx_overrun    = overrun_q;
    assign busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a frame-level model predicts every delivered word,
// and a per-cycle compare process checks the DUT handshake against it.
module tb_uart_rx_cfg;

    localparam int DATA_W = 8;
    localparam int OVS    = 16;
    localparam int DIV_W  = 16;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b0;
    logic             rx = 1'b1;
    logic             cfg_en = 1'b0;
    logic [DIV_W-1:0] cfg_div = 16'd53;
    logic [3:0]       cfg_data_bits = 4'd8;
    logic             cfg_parity_en = 1'b0;
    logic             cfg_parity_odd = 1'b0;
    logic             cfg_stop2 = 1'b0;
    logic             busy;

    uart_rx_cfg_if #(.DATA_W(DATA_W)) rx_if_i ();

    uart_rx_cfg #(
        .DATA_W(DATA_W),
        .OVS   (OVS),
        .DIV_W (DIV_W)
    ) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .rx            (rx),
        .cfg_en        (cfg_en),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2     (cfg_stop2),
        .busy          (busy),
        .rx_if         (rx_if_i)
    );

    always #5 PCLK = ~PCLK;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [9:0]  exp_q[$];
    int          exp_overruns = 0;
    int          overrun_seen = 0;
    int          recv_count = 0;
    int          valid_cycles = 0;
    logic [7:0]  last_data = 8'h00;
    logic        last_perr = 1'b0;
    logic        last_ferr = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int clampBits(input logic [3:0] b);
        if (b < 4'd5) return 5;
        if (int'(b) > DATA_W) return DATA_W;
        return int'(b);
    endfunction

    // Expected word from the frame's content and the current configuration.
    task automatic modelPush(input logic [7:0] data, input logic par_bit, input logic stop_a, input logic stop_b);
        int         n;
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        n    = clampBits(cfg_data_bits);
        d    = data & 8'((1 << n) - 1);
        perr = cfg_parity_en && ((($countones(d) + int'(par_bit) + int'(cfg_parity_odd)) % 2) != 0);
        ferr = !stop_a || (cfg_stop2 && !stop_b);
        exp_q.push_back({perr, ferr, d});
    endtask

    task automatic driveLevel(input logic v, input int cycles);
        rx = v;
        repeat (cycles) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic idle(input int cycles);
        driveLevel(1'b1, cycles);
    endtask

    task automatic doAbort(input int kind);
        checkOutput("busy_before_abort", 32'(busy), 32'd1);
        if (kind == 1) begin
            PRESETn = 1'b0;
            repeat (2) begin @(posedge PCLK); #1; end
            checkOutput("busy_in_reset", 32'(busy), 32'd0);
            checkOutput("valid_in_reset", 32'(rx_if_i.rx_valid), 32'd0);
            rx = 1'b1;
            PRESETn = 1'b1;
        end else begin
            cfg_en = 1'b0;
            repeat (2) begin @(posedge PCLK); #1; end
            checkOutput("busy_after_disable", 32'(busy), 32'd0);
            rx = 1'b1;
            repeat (2) begin @(posedge PCLK); #1; end
            cfg_en = 1'b1;
        end
    endtask

    // Sends one frame; abort_at/spike_at are bit indices (0 = start bit), -1 disables.
    task automatic applyStimulus(input logic [7:0] data, input logic par_bit, input logic stop_a,
                                 input logic stop_b, input bit expect_drop, input int abort_at,
                                 input int abort_kind, input int spike_at);
        int   bit_cyc;
        int   tick_cyc;
        int   n;
        logic seq[$];
        tick_cyc = int'(cfg_div) + 1;
        bit_cyc  = OVS * tick_cyc;
        n        = clampBits(cfg_data_bits);
        seq.push_back(1'b0);
        for (int i = 0; i < n; i++) seq.push_back(data[i]);
        if (cfg_parity_en) seq.push_back(par_bit);
        seq.push_back(stop_a);
        if (cfg_stop2) seq.push_back(stop_b);
        if (abort_at < 0) begin
            if (expect_drop) exp_overruns++;
            else modelPush(data, par_bit, stop_a, stop_b);
        end
        for (int k = 0; k < seq.size(); k++) begin
            if (k == abort_at) begin
                doAbort(abort_kind);
                return;
            end
            if (k == spike_at) begin
                driveLevel(seq[k], bit_cyc / 2 + 4);
                driveLevel(!seq[k], tick_cyc);
                driveLevel(seq[k], bit_cyc - bit_cyc / 2 - 4 - tick_cyc);
            end else begin
                driveLevel(seq[k], bit_cyc);
            end
        end
        rx = 1'b1;
    endtask

    // Per-cycle compare against the model queue.
    initial begin : compare
        forever begin
            @(negedge PCLK);
            if (PRESETn) begin
                if (rx_if_i.rx_overrun) overrun_seen++;
                if (rx_if_i.rx_valid) begin
                    valid_cycles++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL unexpected_word: got data 0x%0h perr %0b ferr %0b, expected no word",
                                 rx_if_i.rx_data, rx_if_i.rx_parity_err, rx_if_i.rx_frame_err);
                    end else begin
                        checkOutput("word", {22'd0, rx_if_i.rx_parity_err, rx_if_i.rx_frame_err, rx_if_i.rx_data},
                                    {22'd0, exp_q[0]});
                        if (rx_if_i.rx_ready) begin
                            last_data = rx_if_i.rx_data;
                            last_perr = rx_if_i.rx_parity_err;
                            last_ferr = rx_if_i.rx_frame_err;
                            recv_count++;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        rx_if_i.rx_ready = 1'b1;
        cfg_en = 1'b1;
        repeat (3) begin @(posedge PCLK); #1; end
        checkOutput("reset_data", 32'(rx_if_i.rx_data), 32'd0);
        checkOutput("reset_valid", 32'(rx_if_i.rx_valid), 32'd0);
        checkOutput("reset_perr", 32'(rx_if_i.rx_parity_err), 32'd0);
        checkOutput("reset_ferr", 32'(rx_if_i.rx_frame_err), 32'd0);
        checkOutput("reset_overrun", 32'(rx_if_i.rx_overrun), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        PRESETn = 1'b1;
        idle(5);

        $display("[TB] 8N1 at divisor 53");
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t1_a5_data", 32'(last_data), 32'hA5);
        checkOutput("t1_a5_errs", 32'({last_perr, last_ferr}), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t1_ff_data", 32'(last_data), 32'hFF);
        checkOutput("t1_recv", 32'(recv_count), 32'd3);
        checkOutput("t1_valid_cycles", 32'(valid_cycles), 32'd3);

        $display("[TB] 7E2 / 7O2 parity");
        cfg_div = 16'd3;
        cfg_data_bits = 4'd7;
        cfg_parity_en = 1'b1;
        cfg_stop2 = 1'b1;
        applyStimulus(8'h41, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t2_even_ok_data", 32'(last_data), 32'h41);
        checkOutput("t2_even_ok_perr", 32'(last_perr), 32'd0);
        applyStimulus(8'h41, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t2_even_bad_perr", 32'(last_perr), 32'd1);
        cfg_parity_odd = 1'b1;
        applyStimulus(8'h41, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t2_odd_ok_perr", 32'(last_perr), 32'd0);

        $display("[TB] stop-bit errors and data-bit clamping");
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_data_bits = 4'd8;
        cfg_stop2 = 1'b0;
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t3_stop_data", 32'(last_data), 32'h3C);
        checkOutput("t3_stop_ferr", 32'(last_ferr), 32'd1);
        cfg_stop2 = 1'b1;
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t3_stop2_ferr", 32'(last_ferr), 32'd1);
        cfg_stop2 = 1'b0;
        cfg_data_bits = 4'd15;
        applyStimulus(8'h96, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t3_clamp_hi", 32'(last_data), 32'h96);
        cfg_data_bits = 4'd2;
        applyStimulus(8'h3F, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t3_clamp_lo", 32'(last_data), 32'h1F);
        cfg_data_bits = 4'd8;

        $display("[TB] false start and data spikes");
        driveLevel(1'b0, 3 * (int'(cfg_div) + 1));
        checkOutput("t4_glitch_busy", 32'(busy), 32'd1);
        idle(80);
        checkOutput("t4_glitch_idle", 32'(busy), 32'd0);
        checkOutput("t4_glitch_recv", 32'(recv_count), 32'd10);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 4);
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 6);
        idle(20);
        checkOutput("t4_spike_recv", 32'(recv_count), 32'd12);

        $display("[TB] overrun with rx_ready low");
        rx_if_i.rx_ready = 1'b0;
        applyStimulus(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        applyStimulus(8'h22, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, -1);
        idle(20);
        checkOutput("t5_held_valid", 32'(rx_if_i.rx_valid), 32'd1);
        checkOutput("t5_held_data", 32'(rx_if_i.rx_data), 32'h11);
        checkOutput("t5_overrun_pulses", 32'(overrun_seen), 32'd1);
        rx_if_i.rx_ready = 1'b1;
        idle(3);
        checkOutput("t5_valid_dropped", 32'(rx_if_i.rx_valid), 32'd0);
        applyStimulus(8'h33, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t5_next_data", 32'(last_data), 32'h33);

        $display("[TB] mid-frame reset and disable");
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 3, 1, -1);
        idle(100);
        checkOutput("t6_reset_idle", 32'(busy), 32'd0);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t6_after_reset", 32'(last_data), 32'h5A);
        applyStimulus(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 3, 2, -1);
        idle(100);
        checkOutput("t6_disable_idle", 32'(busy), 32'd0);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        idle(20);
        checkOutput("t6_after_disable", 32'(last_data), 32'h5A);
        checkOutput("t6_recv", 32'(recv_count), 32'd16);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("overrun_total", 32'(overrun_seen), 32'(exp_overruns));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
